// File: rtl/reg_writeback_ctrl_if.sv
// Bus bundle for reg_writeback_ctrl: issue handshake, data-memory read
// port, register-file write port, scoreboard view and load forwarding.
// The slave modport is the controller's view; master is the environment's.
interface reg_writeback_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
);
  localparam int NREGS = 2 ** ADDR_W;

  // issue side
  logic              ISSUE_VALID;
  logic              ISSUE_READY;
  logic              ISSUE_KIND;
  logic [ADDR_W-1:0] ISSUE_DEST;
  logic [ADDR_W-1:0] ISSUE_SRC1;
  logic [ADDR_W-1:0] ISSUE_SRC2;
  logic [DATA_W-1:0] ALU_RESULT;

  // data memory read port
  logic              MEM_READ;
  logic [DATA_W-1:0] MEM_ADDRESS;
  logic              MEM_BUSYWAIT;
  logic [DATA_W-1:0] MEM_READDATA;

  // register file write port
  logic [DATA_W-1:0] RF_IN;
  logic [ADDR_W-1:0] RF_INADDRESS;
  logic              RF_WRITE;

  // scoreboard and forwarding
  logic [NREGS-1:0]  PENDING;
  logic              FWD_VALID;
  logic [ADDR_W-1:0] FWD_ADDR;
  logic [DATA_W-1:0] FWD_DATA;

  modport slave (
    input  ISSUE_VALID, ISSUE_KIND, ISSUE_DEST, ISSUE_SRC1, ISSUE_SRC2,
    input  ALU_RESULT, MEM_BUSYWAIT, MEM_READDATA,
    output ISSUE_READY, MEM_READ, MEM_ADDRESS,
    output RF_IN, RF_INADDRESS, RF_WRITE,
    output PENDING, FWD_VALID, FWD_ADDR, FWD_DATA
  );

  modport master (
    output ISSUE_VALID, ISSUE_KIND, ISSUE_DEST, ISSUE_SRC1, ISSUE_SRC2,
    output ALU_RESULT, MEM_BUSYWAIT, MEM_READDATA,
    input  ISSUE_READY, MEM_READ, MEM_ADDRESS,
    input  RF_IN, RF_INADDRESS, RF_WRITE,
    input  PENDING, FWD_VALID, FWD_ADDR, FWD_DATA
  );
endinterface

// File: rtl/reg_writeback_ctrl.sv
// reg_writeback_ctrl: write-side sequencer for the register file.
// ALU results are written one cycle after issue; loads go through a
// three-state memory FSM (IDLE -> REQ -> WB) and are written one cycle
// after MEM_BUSYWAIT falls. A per-register scoreboard (PENDING) marks
// destinations with a load in flight and stalls RAW/WAW dependents.
// Optional feature macro: LOAD_FWD_EN (load data forwarding during WB and
// scoreboard masking of the register being written back).
module reg_writeback_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic CLK,
  input  logic RESET,
  reg_writeback_ctrl_if.slave bus
);
  localparam int NREGS = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WB   = 2'd2
  } state_t;

  state_t            state_reg;
  logic              busy_q_reg;
  logic [NREGS-1:0]  pending_reg;
  logic [NREGS-1:0]  pending_next;
  logic [ADDR_W-1:0] dest_reg;
  logic              mem_read_reg;
  logic [DATA_W-1:0] mem_address_reg;
  logic [DATA_W-1:0] rf_in_reg;
  logic [ADDR_W-1:0] rf_inaddress_reg;
  logic              rf_write_reg;

`ifdef LOAD_FWD_EN
  logic              fwd_valid_reg;
  logic [ADDR_W-1:0] fwd_addr_reg;
  logic [DATA_W-1:0] fwd_data_reg;
`endif

  // Per-register scoreboard view used for hazard detection, plus the
  // set/clear terms that produce the next scoreboard value.
  logic [NREGS-1:0] hz_mask;
  logic [NREGS-1:0] pend_eff;
  logic [NREGS-1:0] set_bit;
  logic [NREGS-1:0] clr_bit;

  logic done;
  logic hz;
  logic ld_busy;
  logic wb_conf;
  logic issue_ready;
  logic issue_fire;
  logic alu_fire;
  logic load_fire;

  // Completion is the falling edge of busywait while a request is open.
  assign done = (state_reg == ST_REQ) && busy_q_reg && !bus.MEM_BUSYWAIT;

  for (genvar gi = 0; gi < NREGS; gi++) begin : g_sb
`ifdef LOAD_FWD_EN
    // The register being written back is no longer a hazard: its value
    // is on the forwarding path this cycle.
    assign hz_mask[gi] = (state_reg == ST_WB) && (dest_reg == ADDR_W'(gi));
`else
    assign hz_mask[gi] = 1'b0;
`endif
    assign pend_eff[gi]     = pending_reg[gi] & ~hz_mask[gi];
    assign set_bit[gi]      = load_fire && (bus.ISSUE_DEST == ADDR_W'(gi));
    assign clr_bit[gi]      = (state_reg == ST_WB) && (dest_reg == ADDR_W'(gi));
    assign pending_next[gi] = (pending_reg[gi] & ~clr_bit[gi]) | set_bit[gi];
  end

  assign hz = pend_eff[bus.ISSUE_SRC1] | pend_eff[bus.ISSUE_SRC2] |
              pend_eff[bus.ISSUE_DEST];

`ifdef LOAD_FWD_EN
  // WB is leaving the memory port free, so a new load only waits on REQ.
  assign ld_busy = bus.ISSUE_KIND && (state_reg == ST_REQ);
`else
  assign ld_busy = bus.ISSUE_KIND && (state_reg != ST_IDLE);
`endif

  // The write port belongs to the load path in the done cycle and in WB.
  assign wb_conf = (state_reg == ST_WB) || done;

  assign issue_ready = !(hz || ld_busy || wb_conf);
  assign issue_fire  = bus.ISSUE_VALID && issue_ready;
  assign alu_fire    = issue_fire && !bus.ISSUE_KIND;
  assign load_fire   = issue_fire && bus.ISSUE_KIND;

  // Memory FSM, scoreboard and registered write-port / memory outputs.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_reg        <= ST_IDLE;
      busy_q_reg       <= 1'b0;
      pending_reg      <= '0;
      dest_reg         <= '0;
      mem_read_reg     <= 1'b0;
      mem_address_reg  <= '0;
      rf_in_reg        <= '0;
      rf_inaddress_reg <= '0;
      rf_write_reg     <= 1'b0;
`ifdef LOAD_FWD_EN
      fwd_valid_reg    <= 1'b0;
      fwd_addr_reg     <= '0;
      fwd_data_reg     <= '0;
`endif
    end else begin
      busy_q_reg   <= bus.MEM_BUSYWAIT;
      pending_reg  <= pending_next;
      rf_write_reg <= 1'b0;

      case (state_reg)
        ST_IDLE: begin
          if (load_fire) begin
            state_reg       <= ST_REQ;
            mem_read_reg    <= 1'b1;
            mem_address_reg <= bus.ALU_RESULT;
            dest_reg        <= bus.ISSUE_DEST;
          end
        end

        ST_REQ: begin
          if (done) begin
            state_reg        <= ST_WB;
            mem_read_reg     <= 1'b0;
            rf_in_reg        <= bus.MEM_READDATA;
            rf_inaddress_reg <= dest_reg;
            rf_write_reg     <= 1'b1;
`ifdef LOAD_FWD_EN
            fwd_valid_reg    <= 1'b1;
            fwd_addr_reg     <= dest_reg;
            fwd_data_reg     <= bus.MEM_READDATA;
`endif
          end
        end

        ST_WB: begin
`ifdef LOAD_FWD_EN
          fwd_valid_reg <= 1'b0;
          fwd_addr_reg  <= '0;
          fwd_data_reg  <= '0;
`endif
          if (load_fire) begin
            state_reg       <= ST_REQ;
            mem_read_reg    <= 1'b1;
            mem_address_reg <= bus.ALU_RESULT;
            dest_reg        <= bus.ISSUE_DEST;
          end else begin
            state_reg <= ST_IDLE;
          end
        end

        default: begin
          state_reg    <= ST_IDLE;
          mem_read_reg <= 1'b0;
        end
      endcase

      // ALU writes never coincide with a load write: wb_conf blocks them.
      if (alu_fire) begin
        rf_in_reg        <= bus.ALU_RESULT;
        rf_inaddress_reg <= bus.ISSUE_DEST;
        rf_write_reg     <= 1'b1;
      end
    end
  end

  assign bus.ISSUE_READY  = issue_ready;
  assign bus.MEM_READ     = mem_read_reg;
  assign bus.MEM_ADDRESS  = mem_address_reg;
  assign bus.RF_IN        = rf_in_reg;
  assign bus.RF_INADDRESS = rf_inaddress_reg;
  assign bus.RF_WRITE     = rf_write_reg;
  assign bus.PENDING      = pending_reg;

`ifdef LOAD_FWD_EN
  assign bus.FWD_VALID = fwd_valid_reg;
  assign bus.FWD_ADDR  = fwd_addr_reg;
  assign bus.FWD_DATA  = fwd_data_reg;
`else
  assign bus.FWD_VALID = 1'b0;
  assign bus.FWD_ADDR  = '0;
  assign bus.FWD_DATA  = '0;
`endif

endmodule

// File: tb/tb_reg_writeback_ctrl.sv
// Testbench for reg_writeback_ctrl: directed issue/memory sequences, with
// expected register-file writes and memory requests queued at issue time
// and checked by an independent monitor.
module tb_reg_writeback_ctrl;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 3;

  logic CLK = 1'b0;
  logic RESET = 1'b1;

  reg_writeback_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  reg_writeback_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus.slave)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  logic [ADDR_W+DATA_W-1:0] rf_q[$];
  logic [DATA_W-1:0]        mem_q[$];

  int st;
  bit acc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  // Present one instruction until accepted or max_wait cycles elapse.
  task automatic issue(input bit kind, input logic [ADDR_W-1:0] dest,
                       input logic [ADDR_W-1:0] s1, input logic [ADDR_W-1:0] s2,
                       input logic [DATA_W-1:0] data, input int max_wait,
                       output int stalls, output bit accepted);
    bus.ISSUE_VALID = 1'b1;
    bus.ISSUE_KIND  = kind;
    bus.ISSUE_DEST  = dest;
    bus.ISSUE_SRC1  = s1;
    bus.ISSUE_SRC2  = s2;
    bus.ALU_RESULT  = data;
    stalls   = 0;
    accepted = 1'b0;
    while (!accepted && stalls < max_wait) begin
      @(negedge CLK);
      if (bus.ISSUE_READY) begin
        accepted = 1'b1;
        if (kind) mem_q.push_back(data);
        else      rf_q.push_back({dest, data});
      end else begin
        stalls++;
      end
      @(posedge CLK);
      #1;
    end
    bus.ISSUE_VALID = 1'b0;
    $display("issue kind=%0d dest=%0d src=%0d,%0d val=0x%02h accepted=%0b stalls=%0d",
             kind, dest, s1, s2, data, accepted, stalls);
  endtask

  // Drop busywait with read data; the load write is then expected.
  task automatic mem_finish(input logic [DATA_W-1:0] data, input logic [ADDR_W-1:0] dest);
    bus.MEM_BUSYWAIT = 1'b0;
    bus.MEM_READDATA = data;
    rf_q.push_back({dest, data});
  endtask

  // Monitor: every RF write and every new memory request is checked
  // against the scoreboard queues.
  logic mem_read_prev = 1'b0;
  always @(negedge CLK) begin
    logic [ADDR_W+DATA_W-1:0] e;
    logic [DATA_W-1:0] m;
    if (RESET) begin
      mem_read_prev = 1'b0;
    end else begin
      if (bus.RF_WRITE === 1'b1) begin
        if (rf_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rf_unexpected: got reg=%0d data=0x%02h want no write",
                   bus.RF_INADDRESS, bus.RF_IN);
        end else begin
          e = rf_q.pop_front();
          check("rf_addr", 32'(bus.RF_INADDRESS), 32'(e[ADDR_W+DATA_W-1:DATA_W]));
          check("rf_data", 32'(bus.RF_IN), 32'(e[DATA_W-1:0]));
          $display("rf write reg=%0d data=0x%02h", bus.RF_INADDRESS, bus.RF_IN);
        end
      end
      if (bus.MEM_READ === 1'b1 && !mem_read_prev) begin
        if (mem_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL mem_unexpected: got addr=0x%02h want no request", bus.MEM_ADDRESS);
        end else begin
          m = mem_q.pop_front();
          check("mem_addr", 32'(bus.MEM_ADDRESS), 32'(m));
          $display("mem read addr=0x%02h", bus.MEM_ADDRESS);
        end
      end
      mem_read_prev = bus.MEM_READ;
    end
  end

  initial begin
    bus.ISSUE_VALID  = 1'b0;
    bus.ISSUE_KIND   = 1'b0;
    bus.ISSUE_DEST   = '0;
    bus.ISSUE_SRC1   = '0;
    bus.ISSUE_SRC2   = '0;
    bus.ALU_RESULT   = '0;
    bus.MEM_BUSYWAIT = 1'b0;
    bus.MEM_READDATA = '0;

    // reset state
    repeat (2) tick();
    RESET = 1'b0;
    @(negedge CLK);
    check("rst_pending", 32'(bus.PENDING), 0);
    check("rst_mem_read", 32'(bus.MEM_READ), 0);
    check("rst_mem_addr", 32'(bus.MEM_ADDRESS), 0);
    check("rst_rf_write", 32'(bus.RF_WRITE), 0);
    check("rst_rf_in", 32'(bus.RF_IN), 0);
    check("rst_rf_addr", 32'(bus.RF_INADDRESS), 0);
    check("rst_fwd_valid", 32'(bus.FWD_VALID), 0);
    check("rst_ready", 32'(bus.ISSUE_READY), 1);
    tick();

    // ALU writes, then back-to-back including register 0
    issue(1'b0, 3'd3, 3'd0, 3'd1, 8'h5A, 20, st, acc);
    check("alu_acc", 32'(acc), 1);
    check("alu_stalls", 32'(st), 0);
    issue(1'b0, 3'd0, 3'd2, 3'd3, 8'h11, 20, st, acc);
    check("b2b0_stalls", 32'(st), 0);
    issue(1'b0, 3'd7, 3'd4, 3'd5, 8'hEE, 20, st, acc);
    check("b2b1_stalls", 32'(st), 0);
    tick();
    @(negedge CLK);
    check("alu_idle_write", 32'(bus.RF_WRITE), 0);
    tick();

    // load with busywait high for four cycles
    issue(1'b1, 3'd5, 3'd0, 3'd1, 8'h40, 20, st, acc);
    check("ld_acc", 32'(acc), 1);
    bus.MEM_BUSYWAIT = 1'b1;
    @(negedge CLK);
    check("ld_pending", 32'(bus.PENDING), 32'h20);
    check("ld_mem_read", 32'(bus.MEM_READ), 1);
    check("ld_mem_addr", 32'(bus.MEM_ADDRESS), 32'h40);
    repeat (4) tick();
    mem_finish(8'hC3, 3'd5);
    @(negedge CLK);
    check("done_ready", 32'(bus.ISSUE_READY), 0);
    tick();
    @(negedge CLK);
    check("wb_pending", 32'(bus.PENDING), 32'h20);
    check("wb_mem_read", 32'(bus.MEM_READ), 0);
    check("wb_rf_write", 32'(bus.RF_WRITE), 1);
    tick();
    @(negedge CLK);
    check("ld_clear_pending", 32'(bus.PENDING), 0);
    tick();

    // RAW stall: ALU reads the load destination
    issue(1'b1, 3'd2, 3'd0, 3'd0, 8'h22, 20, st, acc);
    bus.MEM_BUSYWAIT = 1'b1;
    fork
      issue(1'b0, 3'd6, 3'd2, 3'd0, 8'h66, 20, st, acc);
      begin
        repeat (3) tick();
        mem_finish(8'hA7, 3'd2);
      end
    join
    check("raw_acc", 32'(acc), 1);
    check("raw_stalls", 32'(st), 5);
    tick();

    // ALU overlapping an in-flight load, then ALU on the done cycle
    issue(1'b1, 3'd1, 3'd0, 3'd0, 8'h81, 20, st, acc);
    bus.MEM_BUSYWAIT = 1'b1;
    issue(1'b0, 3'd4, 3'd6, 3'd7, 8'h44, 20, st, acc);
    check("ovl_stalls", 32'(st), 0);
    @(negedge CLK);
    check("ovl_rf_write", 32'(bus.RF_WRITE), 1);
    check("ovl_mem_read", 32'(bus.MEM_READ), 1);
    tick();
    mem_finish(8'h99, 3'd1);
    issue(1'b0, 3'd5, 3'd0, 3'd0, 8'h55, 20, st, acc);
    check("conf_acc", 32'(acc), 1);
    check("conf_stalls", 32'(st), 2);
    tick();

    // second load while REQ, then WAW on the pending destination
    issue(1'b1, 3'd3, 3'd0, 3'd0, 8'h30, 20, st, acc);
    bus.MEM_BUSYWAIT = 1'b1;
    issue(1'b1, 3'd6, 3'd0, 3'd0, 8'h60, 3, st, acc);
    check("ld2_blocked", 32'(acc), 0);
    @(negedge CLK);
    check("ld2_mem_addr", 32'(bus.MEM_ADDRESS), 32'h30);
    check("ld2_pending", 32'(bus.PENDING), 32'h08);
    tick();
    issue(1'b0, 3'd3, 3'd0, 3'd1, 8'h33, 3, st, acc);
    check("waw_blocked", 32'(acc), 0);
    tick();
    mem_finish(8'h5C, 3'd3);
    repeat (2) tick();
    @(negedge CLK);
    check("ld2_clear_pending", 32'(bus.PENDING), 0);
    tick();

    // reset in the middle of a request
    issue(1'b1, 3'd7, 3'd0, 3'd0, 8'h77, 20, st, acc);
    bus.MEM_BUSYWAIT = 1'b1;
    @(negedge CLK);
    check("rq_pending", 32'(bus.PENDING), 32'h80);
    tick();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    @(negedge CLK);
    check("rq_mem_read", 32'(bus.MEM_READ), 0);
    check("rq_pending_clr", 32'(bus.PENDING), 0);
    check("rq_ready", 32'(bus.ISSUE_READY), 1);
    tick();
    bus.MEM_BUSYWAIT = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      check("rq_no_write", 32'(bus.RF_WRITE), 0);
      tick();
    end
    issue(1'b0, 3'd7, 3'd0, 3'd0, 8'hB4, 20, st, acc);
    check("rq_after_stalls", 32'(st), 0);
    repeat (2) tick();

    check("rf_q_empty", 32'(rf_q.size()), 0);
    check("mem_q_empty", 32'(mem_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
